// File: rtl/deskew_c.sv
// Output de-skew buffer: re-aligns staggered array result lanes into whole rows.
// Optional synchronous flush port enabled by defining DESKEW_FLUSH_EN.
module deskew_c #(
    parameter  int BITS_C  = 16,
    parameter  int DIM     = 8,
    localparam int ROWBITS = $clog2(DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
`ifdef DESKEW_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     vin,
    input  logic signed [BITS_C-1:0] Cin  [DIM],
    output logic signed [BITS_C-1:0] Cout [DIM],
    output logic                     vout,
    output logic [ROWBITS-1:0]       rowcnt,
    output logic                     done
);

    localparam logic [ROWBITS-1:0] LAST = ROWBITS'(DIM - 1);

    logic           clr;
    logic [DIM-1:0] vpipe;

`ifdef DESKEW_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Lane i is issued i cycles late, so it needs DIM-i stages to land beside lane 0.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam int DEPTH = DIM - i;
        logic signed [BITS_C-1:0] st [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < DEPTH; j++) st[j] <= '0;
            end else if (clr) begin
                for (int j = 0; j < DEPTH; j++) st[j] <= '0;
            end else if (en) begin
                st[0] <= Cin[i];
                for (int j = 1; j < DEPTH; j++) st[j] <= st[j-1];
            end
        end

        assign Cout[i] = st[DEPTH-1];
    end

    // Gating with en keeps a stalled row from being counted on every held cycle.
    assign vout = vpipe[DIM-1] & en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe  <= '0;
            rowcnt <= '0;
            done   <= 1'b0;
        end else if (clr) begin
            vpipe  <= '0;
            rowcnt <= '0;
            done   <= 1'b0;
        end else begin
            done <= vout && (rowcnt == LAST);
            if (en) begin
                vpipe <= {vpipe[DIM-2:0], vin};
                if (vout) rowcnt <= (rowcnt == LAST) ? '0 : rowcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deskew_c.sv
// Self-checking bench for deskew_c: skewed-row injector, reference model and row scoreboard.
module tb_deskew_c;

    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int W      = BITS_C * DIM;

    typedef logic [W-1:0] rowp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     vin;
    logic signed [BITS_C-1:0] Cin  [DIM];
    logic signed [BITS_C-1:0] Cout [DIM];
    logic                     vout;
    logic [2:0]               rowcnt;
    logic                     done;
`ifdef DESKEW_FLUSH_EN
    logic                     flush;
`endif

    always #5 clk = ~clk;

    deskew_c #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
`ifdef DESKEW_FLUSH_EN
        .flush  (flush),
`endif
        .vin    (vin),
        .Cin    (Cin),
        .Cout   (Cout),
        .vout   (vout),
        .rowcnt (rowcnt),
        .done   (done)
    );

    int    assertions = 0;
    int    failures   = 0;
    int    t          = 0;
    int    rowStart[$];
    rowp_t rowVal[$];
    rowp_t sb[$];
    int    expRowcnt  = 0;
    bit    expDone    = 1'b0;
    bit    expVout    = 1'b0;
    bit    doFlush    = 1'b0;

    function automatic rowp_t packCout();
        rowp_t r;
        for (int i = 0; i < DIM; i++) r[i*BITS_C +: BITS_C] = Cout[i];
        return r;
    endfunction

    function automatic rowp_t mkRow(int base);
        rowp_t r;
        for (int i = 0; i < DIM; i++) r[i*BITS_C +: BITS_C] = BITS_C'(base + i);
        return r;
    endfunction

    function automatic rowp_t mkExtreme(bit swap);
        rowp_t r;
        for (int i = 0; i < DIM; i++)
            r[i*BITS_C +: BITS_C] = ((i % 2 == 0) ^ swap) ? 16'sh8000 : 16'sh7FFF;
        return r;
    endfunction

    task automatic checkVal(input string tag, input rowp_t obs, input rowp_t exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        rowStart.delete();
        rowVal.delete();
        sb.delete();
        expRowcnt = 0;
        expDone   = 1'b0;
        expVout   = 1'b0;
    endtask

    task automatic addRow(input int s, input rowp_t v);
        rowStart.push_back(s);
        rowVal.push_back(v);
    endtask

    task automatic checkOutput();
        checkVal("vout", rowp_t'(vout), rowp_t'(expVout));
        checkVal("rowcnt", rowp_t'(rowcnt), rowp_t'(expRowcnt));
        checkVal("done", rowp_t'(done), rowp_t'(expDone));
        if (vout === 1'b1) begin
            if (sb.size() == 0) begin
                assertions++;
                failures++;
                $error("[TB] FAIL row: observed %0h expected no row pending", packCout());
            end else begin
                checkVal("row", packCout(), sb.pop_front());
            end
        end
    endtask

    // One clock: drive skewed lanes, check outputs at negedge, advance the model at posedge.
    task automatic applyStimulus(input bit e);
        en  = e;
        vin = 1'b0;
`ifdef DESKEW_FLUSH_EN
        flush = doFlush;
`endif
        for (int i = 0; i < DIM; i++) Cin[i] = '0;
        if (e) begin
            foreach (rowStart[k]) begin
                if (rowStart[k] == t) begin
                    vin = 1'b1;
                    sb.push_back(rowVal[k]);
                end
                for (int i = 0; i < DIM; i++)
                    if (rowStart[k] == t - i) Cin[i] = rowVal[k][i*BITS_C +: BITS_C];
            end
        end else begin
            vin = 1'($urandom_range(0, 1));
            for (int i = 0; i < DIM; i++) Cin[i] = BITS_C'($urandom);
        end
        expVout = 1'b0;
        if (e) foreach (rowStart[k]) if (rowStart[k] == t - DIM) expVout = 1'b1;

        @(negedge clk);
        checkOutput();
        @(posedge clk);
        expDone = expVout && (expRowcnt == DIM - 1);
        if (expVout) expRowcnt = (expRowcnt + 1) % DIM;
        if (doFlush) clearModel();
        if (e) t++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus(1'b1);
    endtask

    // Asserts rst between clock edges and checks the cleared state before any edge.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkVal("rst_cout", packCout(), '0);
        checkVal("rst_vout", rowp_t'(vout), '0);
        checkVal("rst_rowcnt", rowp_t'(rowcnt), '0);
        checkVal("rst_done", rowp_t'(done), '0);
        clearModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int s;
        rst = 1'b1;
        en  = 1'b0;
        vin = 1'b0;
`ifdef DESKEW_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < DIM; i++) Cin[i] = '0;
        doReset();

        $display("[TB] basic align");
        addRow(t, mkRow(100));
        run(DIM + 3);

        $display("[TB] full tile streaming");
        doReset();
        s = t;
        for (int r = 0; r < DIM; r++) addRow(s + r, mkRow(r * 16));
        run(2 * DIM + 3);
        checkVal("tile_rowcnt_wrap", rowp_t'(rowcnt), '0);

        $display("[TB] stall while row in flight");
        s = t;
        addRow(s, mkRow(16'h1000));
        run(4);
        repeat (3) applyStimulus(1'b0);
        run(DIM);

        $display("[TB] signed extremes");
        s = t;
        addRow(s, mkExtreme(1'b0));
        addRow(s + 1, mkExtreme(1'b1));
        run(DIM + 4);

        $display("[TB] reset mid-tile");
        doReset();
        s = t;
        for (int r = 0; r < DIM; r++) addRow(s + r, mkRow(16'h0200 + r * 16));
        run(DIM + 3);
        checkVal("rowcnt_before_rst", rowp_t'(rowcnt), rowp_t'(3));
        doReset();
        s = t;
        for (int r = 0; r < DIM; r++) addRow(s + r, mkRow(16'h0400 + r * 16));
        run(2 * DIM + 3);

`ifdef DESKEW_FLUSH_EN
        $display("[TB] flush mid-stream");
        s = t;
        addRow(s, mkRow(16'h0700));
        addRow(s + 1, mkRow(16'h0800));
        run(4);
        doFlush = 1'b1;
        applyStimulus(1'b0);
        doFlush = 1'b0;
        run(DIM + 3);
`endif

        checkVal("sb_drain", rowp_t'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
